// File: rtl/jk_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module : jk_cmd_driver
// Brief  : FIFO-buffered {op,len} command sequencer driving a JK flip-flop,
//          with a shadow model of q and a sticky divergence flag.
//          Optional flush port enabled by JK_CMD_DRIVER_FLUSH_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module jk_cmd_driver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef JK_CMD_DRIVER_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             busy,
  output logic             done,
  output logic             exp_q,
  output logic             mismatch
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [CNT_W+1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [1:0]       head_op;
  logic [CNT_W-1:0] head_len;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remaining, rem_nxt;
  logic             j_nxt, k_nxt;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
`ifdef JK_CMD_DRIVER_FLUSH_EN
  assign cmd_ready = !full && !flush;
`else
  assign cmd_ready = !full;
`endif
  assign push     = cmd_valid && cmd_ready;
  assign head_op  = mem[rd_ptr][CNT_W+1:CNT_W];
  assign head_len = mem[rd_ptr][CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_len};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
`ifdef JK_CMD_DRIVER_FLUSH_EN
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      j         <= 1'b0;
      k         <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= rem_nxt;
      j         <= j_nxt;
      k         <= k_nxt;
    end
  end

  // A zero length is run as a single cycle, so the counter loads len-1 floored at 0.
  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    j_nxt     = j;
    k_nxt     = k;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        j_nxt = 1'b0;
        k_nxt = 1'b0;
        if (!empty) begin
          pop            = 1'b1;
          state_nxt      = RUN;
          {j_nxt, k_nxt} = head_op;
          rem_nxt        = (head_len == '0) ? '0 : head_len - 1'b1;
        end
      end
      RUN: begin
        if (remaining == '0) begin
          if (!empty) begin
            pop            = 1'b1;
            {j_nxt, k_nxt} = head_op;
            rem_nxt        = (head_len == '0) ? '0 : head_len - 1'b1;
          end else begin
            state_nxt = IDLE;
            j_nxt     = 1'b0;
            k_nxt     = 1'b0;
          end
        end else begin
          rem_nxt = remaining - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        j_nxt     = 1'b0;
        k_nxt     = 1'b0;
      end
    endcase
`ifdef JK_CMD_DRIVER_FLUSH_EN
    if (flush) begin
      state_nxt = IDLE;
      rem_nxt   = '0;
      j_nxt     = 1'b0;
      k_nxt     = 1'b0;
      pop       = 1'b0;
    end
`endif
  end

  assign done = (state == RUN) && (remaining == '0);
  assign busy = (state == RUN) || !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q    <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   exp_q <= 1'b0;
        2'b10:   exp_q <= 1'b1;
        2'b11:   exp_q <= !exp_q;
        default: exp_q <= exp_q;
      endcase
      if (q_fb != exp_q) mismatch <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jk_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module : tb_jk_cmd_driver
// Brief  : Directed self-checking bench for jk_cmd_driver with a JK FF model
//          closing the q feedback loop.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_jk_cmd_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_len;
  logic       j, k;
  logic       q_fb;
  logic       busy, done, exp_q, mismatch;
  logic       ff_q;
  logic       inj;
`ifdef JK_CMD_DRIVER_FLUSH_EN
  logic       flush;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  jk_cmd_driver #(.DEPTH(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef JK_CMD_DRIVER_FLUSH_EN
    .flush     (flush),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .j         (j),
    .k         (k),
    .q_fb      (q_fb),
    .busy      (busy),
    .done      (done),
    .exp_q     (exp_q),
    .mismatch  (mismatch)
  );

  // Downstream JK flip-flop; inj flips the fed-back value to provoke divergence.
  always @(posedge clk) begin
    if (rst) ff_q <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   ff_q <= 1'b0;
        2'b10:   ff_q <= 1'b1;
        2'b11:   ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end
  assign q_fb = ff_q ^ inj;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] op, input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    total++;
    assert (obs === want) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = 4'd0; inj = 1'b0;
`ifdef JK_CMD_DRIVER_FLUSH_EN
    flush = 1'b0;
`endif
    step(); step();
    rst = 1'b0;
    chk("rst_jk", {6'd0, j, k}, 8'h0);
    chk("rst_done", {7'd0, done}, 8'h0);
    chk("rst_expq", {7'd0, exp_q}, 8'h0);
    chk("rst_mism", {7'd0, mismatch}, 8'h0);
    chk("rst_ready", {7'd0, cmd_ready}, 8'h1);
    chk("rst_busy", {7'd0, busy}, 8'h0);

    // single set command, len 3
    offer(2'b10, 4'd3); step(); cmd_valid = 1'b0;
    chk("t1_busy_t", {7'd0, busy}, 8'h1);
    chk("t1_jk_t", {6'd0, j, k}, 8'h0);
    step();
    chk("t1_jk_t1", {6'd0, j, k}, 8'h2);
    chk("t1_done_t1", {7'd0, done}, 8'h0);
    chk("t1_expq_t1", {7'd0, exp_q}, 8'h0);
    step();
    chk("t1_done_t2", {7'd0, done}, 8'h0);
    chk("t1_expq_t2", {7'd0, exp_q}, 8'h1);
    step();
    chk("t1_jk_t3", {6'd0, j, k}, 8'h2);
    chk("t1_done_t3", {7'd0, done}, 8'h1);
    step();
    chk("t1_jk_t4", {6'd0, j, k}, 8'h0);
    chk("t1_done_t4", {7'd0, done}, 8'h0);
    chk("t1_busy_t4", {7'd0, busy}, 8'h0);
    chk("t1_expq_t4", {7'd0, exp_q}, 8'h1);
    chk("t1_mism", {7'd0, mismatch}, 8'h0);

    // back-to-back toggle x4 then reset with len 0
    rst = 1'b1; step(); rst = 1'b0;
    chk("t2_expq0", {7'd0, exp_q}, 8'h0);
    offer(2'b11, 4'd4); step();
    offer(2'b01, 4'd0); step(); cmd_valid = 1'b0;
    chk("t2_jk_a1", {6'd0, j, k}, 8'h3);
    chk("t2_expq_a1", {7'd0, exp_q}, 8'h0);
    step();
    chk("t2_expq_a2", {7'd0, exp_q}, 8'h1);
    step();
    chk("t2_expq_a3", {7'd0, exp_q}, 8'h0);
    chk("t2_done_a3", {7'd0, done}, 8'h0);
    step();
    chk("t2_jk_a4", {6'd0, j, k}, 8'h3);
    chk("t2_done_a4", {7'd0, done}, 8'h1);
    chk("t2_expq_a4", {7'd0, exp_q}, 8'h1);
    step();
    chk("t2_jk_a5", {6'd0, j, k}, 8'h1);
    chk("t2_done_a5", {7'd0, done}, 8'h1);
    chk("t2_expq_a5", {7'd0, exp_q}, 8'h0);
    chk("t2_busy_a5", {7'd0, busy}, 8'h1);
    step();
    chk("t2_jk_a6", {6'd0, j, k}, 8'h0);
    chk("t2_done_a6", {7'd0, done}, 8'h0);
    chk("t2_busy_a6", {7'd0, busy}, 8'h0);
    chk("t2_expq_a6", {7'd0, exp_q}, 8'h0);

    // fill FIFO behind a long command; fifth queued command must wait
    offer(2'b10, 4'd15); step();
    offer(2'b11, 4'd1); step();
    offer(2'b01, 4'd1); step();
    offer(2'b10, 4'd1); step();
    offer(2'b00, 4'd1); step();
    offer(2'b11, 4'd2);
    chk("t3_ready_full", {7'd0, cmd_ready}, 8'h0);
    chk("t3_busy", {7'd0, busy}, 8'h1);
    repeat (11) step();
    chk("t3_ready_b15", {7'd0, cmd_ready}, 8'h0);
    chk("t3_done_b15", {7'd0, done}, 8'h1);
    chk("t3_jk_b15", {6'd0, j, k}, 8'h2);
    step();
    chk("t3_ready_b16", {7'd0, cmd_ready}, 8'h1);
    chk("t3_jk_c1", {6'd0, j, k}, 8'h3);
    chk("t3_done_c1", {7'd0, done}, 8'h1);
    step(); cmd_valid = 1'b0;
    chk("t3_jk_c2", {6'd0, j, k}, 8'h1);
    step();
    chk("t3_jk_c3", {6'd0, j, k}, 8'h2);
    step();
    chk("t3_jk_c4", {6'd0, j, k}, 8'h0);
    chk("t3_done_c4", {7'd0, done}, 8'h1);
    chk("t3_busy_c4", {7'd0, busy}, 8'h1);
    step();
    chk("t3_jk_c5", {6'd0, j, k}, 8'h3);
    chk("t3_done_c5a", {7'd0, done}, 8'h0);
    step();
    chk("t3_done_c5b", {7'd0, done}, 8'h1);
    step();
    chk("t3_busy_end", {7'd0, busy}, 8'h0);
    chk("t3_jk_end", {6'd0, j, k}, 8'h0);
    chk("t3_mism", {7'd0, mismatch}, 8'h0);

    // reset mid-run with a command still queued
    offer(2'b11, 4'd8); step();
    offer(2'b10, 4'd2); step(); cmd_valid = 1'b0;
    step(); step();
    chk("t4_jk_run", {6'd0, j, k}, 8'h3);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t4_jk_rst", {6'd0, j, k}, 8'h0);
    chk("t4_busy_rst", {7'd0, busy}, 8'h0);
    chk("t4_expq_rst", {7'd0, exp_q}, 8'h0);
    chk("t4_done_rst", {7'd0, done}, 8'h0);
    chk("t4_ready_rst", {7'd0, cmd_ready}, 8'h1);
    step();
    chk("t4_busy_after", {7'd0, busy}, 8'h0);
    chk("t4_jk_after", {6'd0, j, k}, 8'h0);
    offer(2'b10, 4'd2); step(); cmd_valid = 1'b0;
    step();
    chk("t4_jk_d1", {6'd0, j, k}, 8'h2);
    chk("t4_done_d1", {7'd0, done}, 8'h0);
    step();
    chk("t4_done_d2", {7'd0, done}, 8'h1);
    step();
    chk("t4_busy_d3", {7'd0, busy}, 8'h0);
    chk("t4_expq_d3", {7'd0, exp_q}, 8'h1);

    // single-cycle q divergence sets the sticky flag
    inj = 1'b1;
    chk("t5_mism_pre", {7'd0, mismatch}, 8'h0);
    step(); inj = 1'b0;
    chk("t5_mism_set", {7'd0, mismatch}, 8'h1);
    repeat (3) step();
    chk("t5_mism_hold", {7'd0, mismatch}, 8'h1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_mism_rst", {7'd0, mismatch}, 8'h0);
    chk("t5_expq_rst", {7'd0, exp_q}, 8'h0);
    step();
    chk("t5_mism_after", {7'd0, mismatch}, 8'h0);

`ifdef JK_CMD_DRIVER_FLUSH_EN
    offer(2'b10, 4'd15); step();
    offer(2'b11, 4'd3); step();
    offer(2'b01, 4'd2); step(); cmd_valid = 1'b0;
    step();
    chk("t6_jk_run", {6'd0, j, k}, 8'h2);
    chk("t6_expq_run", {7'd0, exp_q}, 8'h1);
    flush = 1'b1; offer(2'b11, 4'd1);
    chk("t6_ready_flush", {7'd0, cmd_ready}, 8'h0);
    step(); flush = 1'b0; cmd_valid = 1'b0;
    chk("t6_jk_flush", {6'd0, j, k}, 8'h0);
    chk("t6_busy_flush", {7'd0, busy}, 8'h0);
    chk("t6_done_flush", {7'd0, done}, 8'h0);
    chk("t6_expq_flush", {7'd0, exp_q}, 8'h1);
    step();
    chk("t6_busy_after", {7'd0, busy}, 8'h0);
    chk("t6_jk_after", {6'd0, j, k}, 8'h0);
    chk("t6_mism", {7'd0, mismatch}, 8'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
